// File: rtl/data_bridge_resp.sv
// Data-memory responder: byte-enabled RAM plus a countdown timer with irq.
// Optional timer region is built only when BRIDGE_TIMER_EN is defined.
module data_bridge_resp #(
    parameter int          DM_WORDS   = 3072,
    parameter logic [31:0] TIMER_BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    output logic [31:0] m_data_rdata,
    output logic        irq,
    output logic        err
);

    localparam logic [31:0] RAM_BYTES = 32'(4 * DM_WORDS);
    localparam int          AW        = $clog2(DM_WORDS);

    logic [29:0]   w_word;
    logic [AW-1:0] w_idx;
    logic          w_ram_hit;
    logic          w_wr;
    logic          w_tmr_hit;
    logic [31:0]   w_tmr_rdata;
    logic          w_drop;
    logic          r_err;

    logic [31:0] r_mem [DM_WORDS];

    assign w_word    = m_data_addr[31:2];
    assign w_idx     = w_word[AW-1:0];
    assign w_ram_hit = {w_word, 2'b00} < RAM_BYTES;
    assign w_wr      = |m_data_byteen;

    // Timer registers only accept full-word writes; anything else is dropped.
    assign w_drop = w_wr && !w_ram_hit &&
                    !(w_tmr_hit && (m_data_byteen == 4'hF));

    always_comb begin
        m_data_rdata = 32'h0;
        if (w_ram_hit)
            m_data_rdata = r_mem[w_idx];
        else if (w_tmr_hit)
            m_data_rdata = w_tmr_rdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DM_WORDS; i++)
                r_mem[i] <= 32'h0;
        end else if (w_ram_hit && w_wr) begin
            for (int k = 0; k < 4; k++)
                if (m_data_byteen[k])
                    r_mem[w_idx][8*k +: 8] <= m_data_wdata[8*k +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_err <= 1'b0;
        else
            r_err <= w_drop;
    end

    assign err = r_err;

`ifdef BRIDGE_TIMER_EN
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CNT  = 2'd2;
    localparam logic [1:0] S_INT  = 2'd3;

    logic [29:0] w_tbase;
    logic        w_t_ctrl;
    logic        w_t_preset;
    logic        w_t_count;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_set_pend;

    logic [1:0]  r_state;
    logic        r_en;
    logic        r_mode;
    logic        r_im;
    logic        r_pend;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_irq;

    assign w_tbase     = TIMER_BASE[31:2];
    assign w_t_ctrl    = w_word == w_tbase;
    assign w_t_preset  = w_word == (w_tbase + 30'd1);
    assign w_t_count   = w_word == (w_tbase + 30'd2);
    assign w_tmr_hit   = w_t_ctrl | w_t_preset | w_t_count;
    assign w_wr_ctrl   = w_t_ctrl && (m_data_byteen == 4'hF);
    assign w_wr_preset = w_t_preset && (m_data_byteen == 4'hF);
    assign w_set_pend  = (r_state == S_CNT) && r_en && (r_count == 32'h0);

    always_comb begin
        w_tmr_rdata = 32'h0;
        if (w_t_ctrl)
            w_tmr_rdata = {28'h0, r_pend, r_im, r_mode, r_en};
        else if (w_t_preset)
            w_tmr_rdata = r_preset;
        else if (w_t_count)
            w_tmr_rdata = r_count;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_en     <= 1'b0;
            r_mode   <= 1'b0;
            r_im     <= 1'b0;
            r_pend   <= 1'b0;
            r_preset <= 32'h0;
            r_count  <= 32'h0;
            r_irq    <= 1'b0;
        end else begin
            r_irq <= r_pend & r_im;
            if (w_wr_preset)
                r_preset <= m_data_wdata;
            unique case (r_state)
                S_IDLE: if (r_en) r_state <= S_LOAD;
                S_LOAD: begin
                    r_count <= r_preset;
                    r_state <= S_CNT;
                end
                S_CNT: begin
                    if (!r_en)
                        r_state <= S_IDLE;
                    else if (r_count == 32'h0)
                        r_state <= S_INT;
                    else
                        r_count <= r_count - 32'd1;
                end
                S_INT: begin
                    if (r_mode) begin
                        r_state <= S_LOAD;
                    end else begin
                        r_en    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // A CTRL write overrides the FSM's EN clear; a new INT beats the PEND clear.
            if (w_wr_ctrl) begin
                r_en   <= m_data_wdata[0];
                r_mode <= m_data_wdata[1];
                r_im   <= m_data_wdata[2];
                r_pend <= 1'b0;
            end
            if (w_set_pend)
                r_pend <= 1'b1;
        end
    end

    assign irq = r_irq;
`else
    assign w_tmr_hit   = 1'b0;
    assign w_tmr_rdata = 32'h0;
    assign irq         = 1'b0;
`endif

endmodule

// File: tb/tb_data_bridge_resp.sv
// Directed bench for data_bridge_resp; timer checks follow BRIDGE_TIMER_EN.
`timescale 1ns/1ps
module tb_data_bridge_resp;

    localparam logic [31:0] TB_CTRL   = 32'h0000_7F00;
    localparam logic [31:0] TB_PRESET = 32'h0000_7F04;
    localparam logic [31:0] TB_COUNT  = 32'h0000_7F08;

    logic        clk;
    logic        reset;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_data_rdata;
    logic        irq;
    logic        err;

    int n_tests;
    int n_fail;

    data_bridge_resp dut (
        .clk           (clk),
        .reset         (reset),
        .m_data_addr   (m_data_addr),
        .m_data_wdata  (m_data_wdata),
        .m_data_byteen (m_data_byteen),
        .m_data_rdata  (m_data_rdata),
        .irq           (irq),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be);
        @(negedge clk);
        m_data_addr   = a;
        m_data_wdata  = d;
        m_data_byteen = be;
        @(posedge clk);
        #1;
        m_data_byteen = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        m_data_addr   = a;
        m_data_byteen = 4'h0;
        #1;
        d = m_data_rdata;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] rd;

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        reset         = 1'b0;
        m_data_addr   = 32'h10;
        m_data_wdata  = 32'h0;
        m_data_byteen = 4'h0;
        #1;
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_ram", m_data_rdata, 32'h0);
        #20;
        @(negedge clk);
        reset = 1'b1;

        // RAM byte lanes and same-cycle read-old
        bus_write(32'h10, 32'hAABBCCDD, 4'hF);
        @(negedge clk);
        m_data_addr   = 32'h10;
        m_data_wdata  = 32'h11223344;
        m_data_byteen = 4'b0101;
        #1;
        check("ram_rd_old", m_data_rdata, 32'hAABBCCDD);
        @(posedge clk);
        #1;
        m_data_byteen = 4'h0;
        check("ram_wr_err", {31'h0, err}, 32'h0);
        bus_read(32'h10, rd);
        check("ram_lanes", rd, 32'hAA22CC44);

        bus_write(32'h2FFC, 32'hDEADBEEF, 4'hF);
        check("ram_top_err", {31'h0, err}, 32'h0);
        bus_read(32'h2FFC, rd);
        check("ram_top", rd, 32'hDEADBEEF);
        bus_write(32'h3000, 32'h12345678, 4'hF);
        check("ram_end_err", {31'h0, err}, 32'h1);

        // Unmapped write
        bus_write(32'h5000, 32'hCAFEF00D, 4'hF);
        check("unm_err", {31'h0, err}, 32'h1);
        edges(1);
        check("unm_err_1cyc", {31'h0, err}, 32'h0);
        bus_read(32'h5000, rd);
        check("unm_rd", rd, 32'h0);
        bus_read(32'h10, rd);
        check("unm_ram_kept", rd, 32'hAA22CC44);

`ifdef BRIDGE_TIMER_EN
        // One-shot, PRESET=5
        bus_write(TB_PRESET, 32'd5, 4'hF);
        bus_write(TB_CTRL, 32'h5, 4'hF);
        edges(7);
        bus_read(TB_CTRL, rd);
        check("os_ctrl_w7", rd, 32'h5);
        bus_read(TB_COUNT, rd);
        check("os_cnt_w7", rd, 32'h0);
        edges(1);
        bus_read(TB_CTRL, rd);
        check("os_pend_w8", rd, 32'hD);
        check("os_irq_w8", {31'h0, irq}, 32'h0);
        edges(1);
        check("os_irq_w9", {31'h0, irq}, 32'h1);
        bus_read(TB_CTRL, rd);
        check("os_en_clr", rd, 32'hC);
        edges(3);
        bus_read(TB_COUNT, rd);
        check("os_cnt_idle", rd, 32'h0);
        bus_read(TB_CTRL, rd);
        check("os_ctrl_idle", rd, 32'hC);
        bus_write(TB_CTRL, 32'h0, 4'hF);
        bus_read(TB_CTRL, rd);
        check("os_pend_clr", rd, 32'h0);
        edges(1);
        check("os_irq_clr", {31'h0, irq}, 32'h0);

        // Auto-reload, PRESET=2
        bus_write(TB_PRESET, 32'd2, 4'hF);
        bus_write(TB_CTRL, 32'h7, 4'hF);
        edges(4);
        bus_read(TB_CTRL, rd);
        check("ar_w4", rd, 32'h7);
        edges(1);
        bus_read(TB_CTRL, rd);
        check("ar_w5", rd, 32'hF);
        bus_write(TB_CTRL, 32'h7, 4'hF);
        bus_read(TB_CTRL, rd);
        check("ar_w6_clr", rd, 32'h7);
        edges(3);
        bus_read(TB_CTRL, rd);
        check("ar_w9", rd, 32'h7);
        edges(1);
        bus_read(TB_CTRL, rd);
        check("ar_w10", rd, 32'hF);
        edges(1);
        bus_write(TB_CTRL, 32'h6, 4'hF);
        edges(3);
        bus_read(TB_COUNT, rd);
        check("ar_cnt_held", rd, 32'd2);
        bus_read(TB_CTRL, rd);
        check("ar_ctrl_off", rd, 32'h6);

        // Partial timer write
        bus_write(TB_PRESET, 32'h1234, 4'b0011);
        check("part_err", {31'h0, err}, 32'h1);
        bus_read(TB_PRESET, rd);
        check("part_preset", rd, 32'd2);
        edges(1);
        check("part_err_1cyc", {31'h0, err}, 32'h0);

        // Mid-count asynchronous reset
        bus_write(TB_PRESET, 32'd100, 4'hF);
        bus_write(TB_CTRL, 32'h7, 4'hF);
        edges(110);
        bus_read(TB_COUNT, rd);
        check("mr_cnt", rd, 32'd95);
        check("mr_irq", {31'h0, irq}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("mr_irq_rst", {31'h0, irq}, 32'h0);
        check("mr_err_rst", {31'h0, err}, 32'h0);
        bus_read(TB_CTRL, rd);
        check("mr_ctrl_rst", rd, 32'h0);
        bus_read(TB_COUNT, rd);
        check("mr_cnt_rst", rd, 32'h0);
        bus_read(32'h10, rd);
        check("mr_ram_rst", rd, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // PRESET=0: LOAD, CNT, INT on consecutive edges
        bus_write(TB_CTRL, 32'h5, 4'hF);
        edges(2);
        bus_read(TB_CTRL, rd);
        check("p0_ctrl_w2", rd, 32'h5);
        edges(1);
        bus_read(TB_CTRL, rd);
        check("p0_pend_w3", rd, 32'hD);
`else
        bus_write(TB_CTRL, 32'h5, 4'hF);
        check("nt_ctrl_err", {31'h0, err}, 32'h1);
        bus_read(TB_CTRL, rd);
        check("nt_ctrl_rd", rd, 32'h0);
        bus_write(TB_PRESET, 32'h0, 4'hF);
        check("nt_preset_err", {31'h0, err}, 32'h1);
        edges(10);
        check("nt_irq", {31'h0, irq}, 32'h0);
        check("nt_err_low", {31'h0, err}, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
